// File: rtl/ticket_pkg.sv
// Shared types and defaults for the ticket arbiter: FSM state encoding and
// parameter defaults used by the top and the round-robin picker.
package ticket_pkg;

  localparam int DEF_N_REQ = 4;
  localparam int DEF_WIDTH = 8;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_t;

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: the first asserted req at or after
// (last_grant+1) mod N_REQ wins.
module rr_pick
  import ticket_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ
) (
  input  logic [N_REQ-1:0]         req,
  input  logic [$clog2(N_REQ)-1:0] last_grant,
  output logic                     found,
  output logic [$clog2(N_REQ)-1:0] index
);

  localparam int IW = $clog2(N_REQ);

  int            pos;
  logic [IW-1:0] cand;

  always_comb begin
    found = 1'b0;
    index = '0;
    pos   = 0;
    cand  = '0;
    // Offsets 1..N_REQ so last_grant itself is checked last.
    for (int k = 1; k <= N_REQ; k++) begin
      pos = int'(last_grant) + k;
      if (pos >= N_REQ) pos = pos - N_REQ;
      cand = IW'(pos);
      if (!found && req[cand]) begin
        found = 1'b1;
        index = cand;
      end
    end
  end

endmodule

// File: rtl/ticket_arbiter.sv
// Round-robin arbiter that hands each winner a ticket drawn from a shared
// wrapping counter; every grant is a one-cycle GRANT state followed by IDLE.
module ticket_arbiter
  import ticket_pkg::*;
#(
  parameter int N_REQ = DEF_N_REQ,
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     en,
  input  logic                     clr,
  input  logic [N_REQ-1:0]         req,
  output logic [N_REQ-1:0]         ack,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic [WIDTH-1:0]         ticket,
  output logic                     wrap,
  output logic [WIDTH-1:0]         count,
  output logic                     busy
);

  localparam int IW = $clog2(N_REQ);

  state_t           state_q, state_d;
  logic [N_REQ-1:0] ack_q, ack_d;
  logic [IW-1:0]    grant_id_q, grant_id_d;
  logic [WIDTH-1:0] ticket_q, ticket_d;
  logic             wrap_q, wrap_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [IW-1:0]    last_q, last_d;

  logic             found;
  logic [IW-1:0]    pick;

  rr_pick #(.N_REQ(N_REQ)) u_pick (
    .req        (req),
    .last_grant (last_q),
    .found      (found),
    .index      (pick)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      ack_q      <= '0;
      grant_id_q <= '0;
      ticket_q   <= '0;
      wrap_q     <= 1'b0;
      count_q    <= '0;
      last_q     <= IW'(N_REQ - 1);
    end else begin
      state_q    <= state_d;
      ack_q      <= ack_d;
      grant_id_q <= grant_id_d;
      ticket_q   <= ticket_d;
      wrap_q     <= wrap_d;
      count_q    <= count_d;
      last_q     <= last_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    ack_d      = '0;
    grant_id_d = grant_id_q;
    ticket_d   = ticket_q;
    wrap_d     = 1'b0;
    count_d    = count_q;
    last_d     = last_q;
    unique case (state_q)
      IDLE: begin
        // clr wins over a pending request in the same cycle.
        if (clr) begin
          count_d = '0;
        end else if (en && found) begin
          state_d     = GRANT;
          ack_d[pick] = 1'b1;
          grant_id_d  = pick;
          ticket_d    = count_q;
          wrap_d      = &count_q;
          count_d     = count_q + 1'b1;
          last_d      = pick;
        end
      end
      GRANT: begin
        // req is ignored here; the issued ticket stands even if clr fires.
        state_d = IDLE;
        if (clr) count_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  assign ack      = ack_q;
  assign grant_id = grant_id_q;
  assign ticket   = ticket_q;
  assign wrap     = wrap_q;
  assign count    = count_q;
  assign busy     = (state_q == GRANT);

endmodule

// File: tb/tb_ticket_arbiter.sv
// Scoreboard bench for ticket_arbiter: expected grants are queued with the
// cycle they must appear in and checked by a negedge monitor.
module tb_ticket_arbiter;

  logic       clk = 1'b0;
  logic       rst, en, clr;
  logic [3:0] req;
  logic [3:0] ack;
  logic [1:0] grant_id;
  logic [7:0] ticket;
  logic       wrap;
  logic [7:0] count;
  logic       busy;

  typedef struct {
    int         cyc;
    logic [1:0] id;
    logic [7:0] tk;
    logic       wr;
    logic [7:0] cnt;
  } exp_t;

  exp_t sb[$];
  int   cyc    = 0;
  int   checks = 0;
  int   errors = 0;

  ticket_arbiter #(.N_REQ(4), .WIDTH(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .en       (en),
    .clr      (clr),
    .req      (req),
    .ack      (ack),
    .grant_id (grant_id),
    .ticket   (ticket),
    .wrap     (wrap),
    .count    (count),
    .busy     (busy)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  // Monitor: every ack must match the head of the scoreboard in cycle and content.
  always @(negedge clk) begin
    exp_t e;
    logic [3:0] ea;
    if (sb.size() != 0 && sb[0].cyc < cyc) begin
      e = sb.pop_front();
      checks++; errors++;
      $display("FAIL missed_ack expected id=%0d ticket=%0d at cycle %0d, got ack=0000", e.id, e.tk, e.cyc);
    end
    if (ack !== 4'b0) begin
      if (sb.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_ack cycle=%0d ack=%b expected none", cyc, ack);
      end else begin
        e  = sb.pop_front();
        ea = 4'b0001 << e.id;
        checks++;
        if (e.cyc !== cyc || ack !== ea || grant_id !== e.id || ticket !== e.tk ||
            wrap !== e.wr || count !== e.cnt || busy !== 1'b1) begin
          errors++;
          $display("FAIL grant cycle=%0d ack=%b id=%0d ticket=%0d wrap=%b count=%0d busy=%b; expected cycle=%0d ack=%b id=%0d ticket=%0d wrap=%b count=%0d busy=1",
                   cyc, ack, grant_id, ticket, wrap, count, busy, e.cyc, ea, e.id, e.tk, e.wr, e.cnt);
        end
      end
    end else if (busy !== 1'b0 || wrap !== 1'b0) begin
      checks++; errors++;
      $display("FAIL idle_flags cycle=%0d busy=%b wrap=%b expected 0 0", cyc, busy, wrap);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] id, input logic [7:0] tk, input logic wr, input logic [7:0] cnt);
    exp_t e;
    e.cyc = cyc + 1; e.id = id; e.tk = tk; e.wr = wr; e.cnt = cnt;
    sb.push_back(e);
  endtask

  // Raise r, expect a grant to id next cycle, then drop id's req during GRANT.
  task automatic do_grant(input logic [3:0] r, input logic [1:0] id, input logic [7:0] tk,
                          input logic wr, input logic [7:0] cnt);
    req = r;
    push(id, tk, wr, cnt);
    tick();
    req = r & ~(4'b0001 << id);
    tick();
  endtask

  task automatic apply_reset();
    rst = 1'b1; en = 1'b1; clr = 1'b0; req = 4'b0;
    tick(); tick();
    rst = 1'b0;
  endtask

  task automatic check_count(input string name, input logic [7:0] want);
    checks++;
    if (count !== want) begin
      errors++;
      $display("FAIL %s count=%0d expected %0d", name, count, want);
    end
  endtask

  task automatic check_drained(input string name);
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("FAIL %s pending_grants=%0d expected 0", name, sb.size());
      sb.delete();
    end
  endtask

  task automatic test_reset();
    apply_reset();
    checks++;
    if (ack !== 4'b0 || busy !== 1'b0 || wrap !== 1'b0 || ticket !== 8'd0 ||
        grant_id !== 2'd0 || count !== 8'd0) begin
      errors++;
      $display("FAIL reset_state ack=%b busy=%b wrap=%b ticket=%0d id=%0d count=%0d expected all zero",
               ack, busy, wrap, ticket, grant_id, count);
    end
  endtask

  task automatic test_single();
    apply_reset();
    do_grant(4'b0100, 2'd2, 8'd0, 1'b0, 8'd1);
    tick(); tick(); tick();
    check_count("single_count", 8'd1);
    checks++;
    if (ticket !== 8'd0 || grant_id !== 2'd2) begin
      errors++;
      $display("FAIL single_hold ticket=%0d id=%0d expected 0 2", ticket, grant_id);
    end
    check_drained("single");
  endtask

  task automatic test_round_robin();
    apply_reset();
    for (int i = 0; i < 5; i++)
      do_grant(4'b1111, 2'(i % 4), 8'(i), 1'b0, 8'(i + 1));
    req = 4'b0;
    tick();
    check_count("rr_count", 8'd5);
    check_drained("round_robin");
  endtask

  task automatic test_wrap();
    apply_reset();
    for (int i = 0; i < 255; i++)
      do_grant(4'b0001, 2'd0, 8'(i), 1'b0, 8'(i + 1));
    do_grant(4'b0001, 2'd0, 8'd255, 1'b1, 8'd0);
    check_count("wrap_count", 8'd0);
    do_grant(4'b0001, 2'd0, 8'd0, 1'b0, 8'd1);
    check_drained("wrap");
  endtask

  task automatic test_clear();
    apply_reset();
    for (int i = 0; i < 5; i++)
      do_grant(4'b0001, 2'd0, 8'(i), 1'b0, 8'(i + 1));
    check_count("clr_pre", 8'd5);
    clr = 1'b1; req = 4'b0001;
    tick();
    clr = 1'b0;
    check_count("clr_idle", 8'd0);
    do_grant(4'b0001, 2'd0, 8'd0, 1'b0, 8'd1);
    // clr during GRANT: ticket already issued, counter cleared at the end edge.
    req = 4'b0001;
    push(2'd0, 8'd1, 1'b0, 8'd2);
    tick();
    req = 4'b0; clr = 1'b1;
    tick();
    clr = 1'b0;
    check_count("clr_grant", 8'd0);
    check_drained("clear");
  endtask

  task automatic test_reset_mid_grant();
    apply_reset();
    for (int i = 0; i < 7; i++)
      do_grant(4'b0001, 2'd0, 8'(i), 1'b0, 8'(i + 1));
    req = 4'b0001;
    push(2'd0, 8'd7, 1'b0, 8'd8);
    tick();
    rst = 1'b1; req = 4'b0;
    tick();
    rst = 1'b0;
    checks++;
    if (ack !== 4'b0 || busy !== 1'b0 || count !== 8'd0) begin
      errors++;
      $display("FAIL rst_mid_grant ack=%b busy=%b count=%0d expected 0 0 0", ack, busy, count);
    end
    // last_grant was reset to 3, so requester 0 beats 3.
    do_grant(4'b1001, 2'd0, 8'd0, 1'b0, 8'd1);
    req = 4'b0;
    tick();
    check_drained("reset_mid_grant");
  endtask

  task automatic test_enable();
    apply_reset();
    do_grant(4'b0001, 2'd0, 8'd0, 1'b0, 8'd1);
    en = 1'b0; req = 4'b1000;
    tick(); tick(); tick();
    check_count("en_low_count", 8'd1);
    en = 1'b1;
    do_grant(4'b1000, 2'd3, 8'd1, 1'b0, 8'd2);
    en = 1'b0; clr = 1'b1;
    tick();
    clr = 1'b0; en = 1'b1;
    check_count("en_low_clr", 8'd0);
    check_drained("enable");
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; clr = 1'b0; req = 4'b0;
    test_reset();
    test_single();
    test_round_robin();
    test_wrap();
    test_clear();
    test_reset_mid_grant();
    test_enable();
    tick(); tick();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
